// File: rtl/mipsfpga_ahb_arbiter_pkg.sv
// Shared encodings for the two-master AHB-lite arbiter: HTRANS codes,
// data-phase owner codes and small helpers.
package mipsfpga_ahb_arbiter_pkg;

   localparam logic [1:0] H_IDLE   = 2'b00;
   localparam logic [1:0] H_BUSY   = 2'b01;
   localparam logic [1:0] H_NONSEQ = 2'b10;
   localparam logic [1:0] H_SEQ    = 2'b11;

   // Encoding is visible on dbg_data_owner: 0 = M0, 1 = M1, 2 = none.
   typedef enum logic [1:0] {
      OWN_M0        = 2'd0,
      OWN_M1        = 2'd1,
      H_MASTER_NONE = 2'd2
   } data_owner_e;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/ahb_master_hold.sv
// Per-master data-phase hold: captures bus read data/response when the
// master is stalled, and presents held or live values back to it.
module ahb_master_hold (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        capture,
   input  logic        hready_m,
   input  logic [31:0] bus_rdata,
   input  logic        bus_resp,
   output logic [31:0] rdata,
   output logic        resp,
   output logic        hold_valid
);

   logic [31:0] hold_rdata;
   logic        hold_resp;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         hold_valid <= 1'b0;
         hold_rdata <= '0;
         hold_resp  <= 1'b0;
      end else if (capture) begin
         hold_valid <= 1'b1;
         hold_rdata <= bus_rdata;
         hold_resp  <= bus_resp;
      end else if (hready_m) begin
         hold_valid <= 1'b0;
      end
   end

   assign rdata = hold_valid ? hold_rdata : bus_rdata;
   assign resp  = hold_valid ? hold_resp  : bus_resp;

endmodule

// File: rtl/mipsfpga_ahb_arbiter.sv
// Two-master AHB-lite arbiter: shares one address phase between M0 (core)
// and M1 (DMA/debug) with bounded tenure, and routes data-phase returns.
module mipsfpga_ahb_arbiter
   import mipsfpga_ahb_arbiter_pkg::*;
#(
   parameter int unsigned MAX_BURST = 8
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic [31:0] M0_HADDR,
   input  logic [1:0]  M0_HTRANS,
   input  logic        M0_HWRITE,
   input  logic [2:0]  M0_HSIZE,
   input  logic [2:0]  M0_HBURST,
   input  logic [3:0]  M0_HPROT,
   input  logic        M0_HMASTLOCK,
   input  logic [31:0] M0_HWDATA,
   output logic [31:0] M0_HRDATA,
   output logic        M0_HREADY,
   output logic        M0_HRESP,
   input  logic [31:0] M1_HADDR,
   input  logic [1:0]  M1_HTRANS,
   input  logic        M1_HWRITE,
   input  logic [2:0]  M1_HSIZE,
   input  logic [2:0]  M1_HBURST,
   input  logic [3:0]  M1_HPROT,
   input  logic        M1_HMASTLOCK,
   input  logic [31:0] M1_HWDATA,
   output logic [31:0] M1_HRDATA,
   output logic        M1_HREADY,
   output logic        M1_HRESP,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [3:0]  HPROT,
   output logic        HMASTLOCK,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP,
   output logic        HMASTER,
   output logic [1:0]  dbg_data_owner,
   output logic [7:0]  dbg_beat_cnt,
   output logic [1:0]  dbg_hold_valid
);

   localparam logic [7:0] MAX_BURST_C = MAX_BURST[7:0];

   // Handshake: a master's transfer is accepted on a rising edge where its
   // HTRANS[1]=1 and the HREADY it sees is 1; its data phase completes on
   // the next edge where its HREADY is 1 again.
   logic        addr_owner, addr_owner_nxt;
   data_owner_e data_owner, data_owner_nxt;
   logic [7:0]  beat_cnt, beat_cnt_nxt;
   logic [1:0]  own_htrans, oth_htrans;
   logic        own_lock, handover;
   logic        m0_capture, m1_capture;

   assign own_htrans = addr_owner ? M1_HTRANS : M0_HTRANS;
   assign oth_htrans = addr_owner ? M0_HTRANS : M1_HTRANS;
   assign own_lock   = addr_owner ? M1_HMASTLOCK : M0_HMASTLOCK;

   // Never break a locked sequence or a burst already in SEQ/BUSY.
   assign handover = HREADY && (oth_htrans == H_NONSEQ) && !own_lock &&
                     ((own_htrans == H_IDLE) || (own_htrans == H_NONSEQ)) &&
                     ((own_htrans == H_IDLE) || (beat_cnt >= MAX_BURST_C));

   assign HADDR     = addr_owner ? M1_HADDR     : M0_HADDR;
   assign HTRANS    = handover   ? H_IDLE       : own_htrans;
   assign HWRITE    = addr_owner ? M1_HWRITE    : M0_HWRITE;
   assign HSIZE     = addr_owner ? M1_HSIZE     : M0_HSIZE;
   assign HBURST    = addr_owner ? M1_HBURST    : M0_HBURST;
   assign HPROT     = addr_owner ? M1_HPROT     : M0_HPROT;
   assign HMASTLOCK = addr_owner ? M1_HMASTLOCK : M0_HMASTLOCK;
   assign HMASTER   = addr_owner;

   always_comb begin
      HWDATA = '0;
      case (data_owner)
         OWN_M0:  HWDATA = M0_HWDATA;
         OWN_M1:  HWDATA = M1_HWDATA;
         default: HWDATA = '0;
      endcase
   end

   always_comb begin
      addr_owner_nxt = addr_owner;
      data_owner_nxt = data_owner;
      beat_cnt_nxt   = beat_cnt;
      if (HREADY) begin
         data_owner_nxt = HTRANS[1] ? (addr_owner ? OWN_M1 : OWN_M0) : H_MASTER_NONE;
         if (handover) begin
            addr_owner_nxt = ~addr_owner;
            beat_cnt_nxt   = '0;
         end else if (HTRANS[1]) begin
            beat_cnt_nxt = sat_inc(beat_cnt);
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         addr_owner <= 1'b0;
         data_owner <= H_MASTER_NONE;
         beat_cnt   <= '0;
      end else begin
         addr_owner <= addr_owner_nxt;
         data_owner <= data_owner_nxt;
         beat_cnt   <= beat_cnt_nxt;
      end
   end

   // The handover loser is stalled for one cycle even if it has gone IDLE,
   // so its final data phase lands in the hold register.
   always_comb begin
      M0_HREADY = 1'b1;
      if (!addr_owner && !handover)
         M0_HREADY = HREADY;
      else if (M0_HTRANS[1] || (handover && !addr_owner))
         M0_HREADY = 1'b0;
      M1_HREADY = 1'b1;
      if (addr_owner && !handover)
         M1_HREADY = HREADY;
      else if (M1_HTRANS[1] || (handover && addr_owner))
         M1_HREADY = 1'b0;
   end

   assign m0_capture = (data_owner == OWN_M0) && HREADY && !M0_HREADY;
   assign m1_capture = (data_owner == OWN_M1) && HREADY && !M1_HREADY;

   ahb_master_hold u_hold_m0 (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .capture    (m0_capture),
      .hready_m   (M0_HREADY),
      .bus_rdata  (HRDATA),
      .bus_resp   (HRESP),
      .rdata      (M0_HRDATA),
      .resp       (M0_HRESP),
      .hold_valid (dbg_hold_valid[0])
   );

   ahb_master_hold u_hold_m1 (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .capture    (m1_capture),
      .hready_m   (M1_HREADY),
      .bus_rdata  (HRDATA),
      .bus_resp   (HRESP),
      .rdata      (M1_HRDATA),
      .resp       (M1_HRESP),
      .hold_valid (dbg_hold_valid[1])
   );

   assign dbg_data_owner = data_owner;
   assign dbg_beat_cnt   = beat_cnt;

endmodule
